// File: rtl/tlc_pkg.sv
// Shared phase, light and width definitions for the multi-way traffic-light controller.
package tlc_pkg;

  localparam int unsigned PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    ALLRED = 2'b10
  } phase_e;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  // Lamp pattern of the owning approach for a given phase.
  function automatic logic [2:0] light_code(input phase_e ph);
    case (ph)
      GREEN:   light_code = LIGHT_GREEN;
      YELLOW:  light_code = LIGHT_YELLOW;
      default: light_code = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin next-way selector: first approach with demand after active_way, own way excluded.
module tlc_rr_pick #(
  parameter int unsigned N_WAYS = 4
) (
  input  logic [$clog2(N_WAYS)-1:0] active_way,
  input  logic [N_WAYS-1:0]         demand,
  output logic [$clog2(N_WAYS)-1:0] next_way,
  output logic                      found
);

  localparam int unsigned WAY_W = $clog2(N_WAYS);

  logic [WAY_W:0]   sum;
  logic [WAY_W-1:0] idx;

  always_comb begin
    next_way = active_way;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 1; k < int'(N_WAYS); k++) begin
      sum = {1'b0, active_way} + (WAY_W+1)'(k);
      if (sum >= (WAY_W+1)'(N_WAYS)) sum = sum - (WAY_W+1)'(N_WAYS);
      idx = sum[WAY_W-1:0];
      if (!found && demand[idx]) begin
        found    = 1'b1;
        next_way = idx;
      end
    end
  end

endmodule

// File: rtl/multi_way_tlc.sv
// N-way traffic-light controller stepped by an external tick strobe.
// Define TLC_DEMAND_SKIP_EN to serve only approaches with waiting demand.
module multi_way_tlc
  import tlc_pkg::*;
#(
  parameter int unsigned N_WAYS       = 4,
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 1,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      force_next,
  input  logic [N_WAYS-1:0]         demand,
  output logic [3*N_WAYS-1:0]       lights,
  output logic [$clog2(N_WAYS)-1:0] active_way,
  output logic [1:0]                phase,
  output logic [CNT_W-1:0]          elapsed
);

  localparam int unsigned WAY_W  = $clog2(N_WAYS);
  localparam int unsigned A_LAST = (ALLRED_TICKS == 0) ? 0 : ALLRED_TICKS - 1;

  localparam logic [CNT_W-1:0] G_LAST_C = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST_C = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LAST_C = CNT_W'(A_LAST);

  localparam logic [3*N_WAYS-1:0] RST_LIGHTS = {{(N_WAYS-1){LIGHT_RED}}, LIGHT_GREEN};

  phase_e                phase_q, phase_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [WAY_W-1:0]      next_q, next_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3*N_WAYS-1:0]   lights_q, lights_d;
  logic [WAY_W-1:0]      seq_next;
  logic                  green_end;

  assign seq_next  = (way_q == WAY_W'(N_WAYS - 1)) ? '0 : way_q + WAY_W'(1);
  assign green_end = force_next || (tick && (cnt_q == G_LAST_C));

`ifdef TLC_DEMAND_SKIP_EN
  logic [WAY_W-1:0] pick_way;
  logic             pick_found;

  tlc_rr_pick #(.N_WAYS(N_WAYS)) u_rr_pick (
    .active_way (way_q),
    .demand     (demand),
    .next_way   (pick_way),
    .found      (pick_found)
  );
`else
  logic unused_demand;
  assign unused_demand = ^{demand, seq_next};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= GREEN;
      way_q    <= '0;
      next_q   <= '0;
      cnt_q    <= '0;
      lights_q <= RST_LIGHTS;
    end else begin
      phase_q  <= phase_d;
      way_q    <= way_d;
      next_q   <= next_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
    end
  end

  // Phase sequencing; force_next pre-empts a same-cycle tick in GREEN.
  always_comb begin
    phase_d  = phase_q;
    way_d    = way_q;
    next_d   = next_q;
    cnt_d    = cnt_q;
    lights_d = '0;
    case (phase_q)
      GREEN: begin
        if (green_end) begin
          cnt_d = '0;
`ifdef TLC_DEMAND_SKIP_EN
          if (pick_found) begin
            phase_d = YELLOW;
            next_d  = pick_way;
          end
`else
          phase_d = YELLOW;
          next_d  = seq_next;
`endif
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      YELLOW: begin
        if (tick) begin
          if (cnt_q == Y_LAST_C) begin
            cnt_d = '0;
            if (ALLRED_TICKS == 0) begin
              phase_d = GREEN;
              way_d   = next_q;
            end else begin
              phase_d = ALLRED;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ALLRED: begin
        if (tick) begin
          if (cnt_q == A_LAST_C) begin
            cnt_d   = '0;
            phase_d = GREEN;
            way_d   = next_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        phase_d = GREEN;
        way_d   = '0;
        cnt_d   = '0;
      end
    endcase
    // Lamps follow the next state so they update alongside phase.
    for (int i = 0; i < int'(N_WAYS); i++) begin
      lights_d[3*i +: 3] = LIGHT_RED;
      if (WAY_W'(i) == way_d) lights_d[3*i +: 3] = light_code(phase_d);
    end
  end

  assign lights     = lights_q;
  assign active_way = way_q;
  assign phase      = phase_q;
  assign elapsed    = cnt_q;

endmodule

// File: tb/tb_multi_way_tlc.sv
// Directed bench: 4-way default controller plus a 3-way controller without all-red.
module tb_multi_way_tlc;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       force_next;
  logic [3:0] dmd_a;
  logic [2:0] dmd_b;

  logic [11:0] lights_a;
  logic [1:0]  way_a;
  logic [1:0]  phase_a;
  logic [7:0]  el_a;
  logic [8:0]  lights_b;
  logic [1:0]  way_b;
  logic [1:0]  phase_b;
  logic [7:0]  el_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_way_tlc dut_a (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .force_next (force_next),
    .demand     (dmd_a),
    .lights     (lights_a),
    .active_way (way_a),
    .phase      (phase_a),
    .elapsed    (el_a)
  );

  multi_way_tlc #(.N_WAYS(3), .ALLRED_TICKS(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .force_next (force_next),
    .demand     (dmd_b),
    .lights     (lights_b),
    .active_way (way_b),
    .phase      (phase_b),
    .elapsed    (el_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic f);
    tick       = t;
    force_next = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Expected lamp word from way/phase (0 green, 1 yellow, 2 all-red).
  function automatic logic [31:0] exp_lights(input int nw, input int w, input int ph);
    logic [31:0] l;
    l = '0;
    for (int i = 0; i < nw; i++) begin
      if (ph == 2 || i != w) l[3*i +: 3] = 3'b100;
      else if (ph == 0)      l[3*i +: 3] = 3'b001;
      else                   l[3*i +: 3] = 3'b010;
    end
    return l;
  endfunction

  function automatic int nonred(input logic [31:0] l, input int nw);
    int c;
    c = 0;
    for (int i = 0; i < nw; i++) if (l[3*i +: 3] != 3'b100) c++;
    return c;
  endfunction

  initial begin
    tick = 1'b0; force_next = 1'b0; rst = 1'b1;
    dmd_a = 4'b1111; dmd_b = 3'b111;
    do_reset();

    chk("rst_phase_a", 32'(phase_a), 0);
    chk("rst_way_a", 32'(way_a), 0);
    chk("rst_el_a", 32'(el_a), 0);
    chk("rst_lights_a", 32'(lights_a), 32'h921);
    chk("rst_lights_b", 32'(lights_b), 32'h121);

    // Tick held high: A has period 24 (6 per way), B has period 15 (5 per way).
    for (int t = 1; t <= 40; t++) begin
      int p, r, w, ph, el;
      step(1'b1, 1'b0);
      p = t % 24; w = p / 6; r = p % 6;
      ph = (r < 4) ? 0 : (r == 4) ? 1 : 2;
      el = (r < 4) ? r : 0;
      chk("rot_phase_a", 32'(phase_a), 32'(ph));
      chk("rot_el_a", 32'(el_a), 32'(el));
      if (ph != 2) chk("rot_way_a", 32'(way_a), 32'(w));
      chk("rot_lights_a", 32'(lights_a), exp_lights(4, w, ph));
      chk("rot_nonred_a", 32'(nonred(32'(lights_a), 4)), (ph == 2) ? 0 : 1);
      p = t % 15; w = p / 5; r = p % 5;
      ph = (r < 4) ? 0 : 1;
      el = (r < 4) ? r : 0;
      chk("rot_phase_b", 32'(phase_b), 32'(ph));
      chk("rot_way_b", 32'(way_b), 32'(w));
      chk("rot_el_b", 32'(el_b), 32'(el));
      chk("rot_lights_b", 32'(lights_b), exp_lights(3, w, ph));
    end

    // Manual advance on way 2 at elapsed 1.
    do_reset();
    for (int t = 0; t < 13; t++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("pre_force_way", 32'(way_a), 2);
    chk("pre_force_el", 32'(el_a), 1);
    step(1'b0, 1'b1);
    chk("force_phase", 32'(phase_a), 1);
    chk("force_way", 32'(way_a), 2);
    chk("force_el", 32'(el_a), 0);
    chk("force_lights", 32'(lights_a), 32'h8A4);
    step(1'b0, 1'b1);
    chk("force_in_yel_phase", 32'(phase_a), 1);
    chk("force_in_yel_el", 32'(el_a), 0);
    step(1'b1, 1'b0);
    chk("force_allred", 32'(lights_a), 32'h924);
    chk("force_allred_phase", 32'(phase_a), 2);
    step(1'b1, 1'b0);
    chk("force_next_green_way", 32'(way_a), 3);
    chk("force_next_green_lights", 32'(lights_a), 32'h324);

    // force_next and tick together: tick is not counted.
    step(1'b1, 1'b0);
    chk("ft_pre_el", 32'(el_a), 1);
    step(1'b1, 1'b1);
    chk("ft_phase", 32'(phase_a), 1);
    chk("ft_el", 32'(el_a), 0);
    chk("ft_way", 32'(way_a), 3);
    step(1'b0, 1'b0);

    // Asynchronous reset in the middle of way 1 yellow.
    do_reset();
    for (int t = 0; t < 10; t++) step(1'b1, 1'b0);
    tick = 1'b0;
    chk("pre_rst_phase", 32'(phase_a), 1);
    chk("pre_rst_way", 32'(way_a), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_phase", 32'(phase_a), 0);
    chk("mid_rst_way", 32'(way_a), 0);
    chk("mid_rst_el", 32'(el_a), 0);
    chk("mid_rst_lights", 32'(lights_a), 32'h921);
    step(1'b0, 1'b0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) step(1'b1, 1'b0);
    chk("post_rst_way", 32'(way_a), 1);
    chk("post_rst_phase", 32'(phase_a), 0);

`ifdef TLC_DEMAND_SKIP_EN
    // Demand only on own way: green is extended.
    do_reset();
    dmd_a = 4'b0001;
    for (int t = 0; t < 4; t++) step(1'b1, 1'b0);
    chk("dm_hold_phase", 32'(phase_a), 0);
    chk("dm_hold_way", 32'(way_a), 0);
    chk("dm_hold_el", 32'(el_a), 0);
    // Demand on way 3 only: ways 1 and 2 are skipped.
    dmd_a = 4'b1000;
    for (int t = 0; t < 4; t++) step(1'b1, 1'b0);
    chk("dm_yel_phase", 32'(phase_a), 1);
    step(1'b1, 1'b0);
    chk("dm_allred_phase", 32'(phase_a), 2);
    step(1'b1, 1'b0);
    chk("dm_skip_way", 32'(way_a), 3);
    chk("dm_skip_lights", 32'(lights_a), 32'h324);
    dmd_a = 4'b1111;
`endif

    step(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_way_tlc.md
# multi_way_tlc

Parametrised traffic-light controller for an N-way junction, driven by an external tick strobe instead of a derived slow clock. Each approach cycles through green, yellow and all-red clearance, with tick-programmable durations. A manual-advance input ends the current green early through a proper yellow phase. Optional demand-based skipping serves only approaches with waiting vehicles.

## Interface
- N_WAYS, 4, number of approaches (>= 2)
- GREEN_TICKS, 4, green duration in ticks (>= 1)
- YELLOW_TICKS, 1, yellow duration in ticks (>= 1)
- ALLRED_TICKS, 1, all-red clearance in ticks (>= 0; 0 removes the phase)
- CNT_W, 8, phase counter width; must hold max(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle time-base strobe; all durations are counted in ticks
- force_next  in  1  manual advance, sampled every cycle
- demand  in  N_WAYS  per-approach vehicle sensor, level
- lights  out  3*N_WAYS  way i at [3i+2:3i]: 3'b001 green, 3'b010 yellow, 3'b100 red
- active_way  out  $clog2(N_WAYS)  approach currently owning green/yellow
- phase  out  2  00 GREEN, 01 YELLOW, 10 ALLRED
- elapsed  out  CNT_W  ticks elapsed in current phase

## Operation
- Reset values:
  - phase = GREEN, active_way = 0, elapsed = 0.
  - lights: way 0 = 001, all other ways = 100.
- GREEN, on a tick:
  - If elapsed == GREEN_TICKS-1: go to YELLOW, elapsed = 0, latch next_way.
  - Otherwise elapsed increments.
- YELLOW, on a tick with elapsed == YELLOW_TICKS-1:
  - Go to ALLRED, or go directly to GREEN of next_way if ALLRED_TICKS == 0.
- ALLRED, on a tick with elapsed == ALLRED_TICKS-1:
  - Go to GREEN, active_way = next_way, elapsed = 0.
- force_next:
  - In GREEN: next cycle is YELLOW with elapsed = 0 and next_way latched. Yellow is never bypassed.
  - In YELLOW or ALLRED: ignored.
- force_next and tick in the same cycle: force_next wins; the tick is not counted.
- next_way without the macro: (active_way + 1) mod N_WAYS, wrapping N_WAYS-1 -> 0.
- Lights:
  - Only active_way is ever non-red.
  - In ALLRED every way is 100.
  - No two ways are green or yellow simultaneously under any input sequence.
- Counter:
  - elapsed never exceeds the current phase's limit minus 1.
  - Arithmetic is unsigned CNT_W, with no wrap.
- tick held high: counts one tick per clk.
- Reset mid-phase: immediate return to reset values. Any latched next_way is discarded.

## Timing
- All outputs are registered.
- A qualifying tick or force_next at edge k produces the new phase/lights in the cycle after edge k (1-cycle latency).
- Full rotation without the macro, in ticks: N_WAYS*(GREEN_TICKS+YELLOW_TICKS+ALLRED_TICKS).
- No combinational path from inputs to outputs.

## Configuration
- TLC_DEMAND_SKIP_EN defined:
  - At green expiry, next_way is the first way with demand set, searching round-robin from active_way+1.
  - If no other way has demand, phase stays GREEN on the same way with elapsed = 0 (green extension).
  - force_next with no other demand also holds green.
  - demand is sampled only at the expiry/force cycle.
- TLC_DEMAND_SKIP_EN undefined: demand is unused; fixed rotation.

## Structure
- Package tlc_pkg:
  - Phase enum (GREEN/YELLOW/ALLRED).
  - Light encodings LIGHT_GREEN/LIGHT_YELLOW/LIGHT_RED.
  - Phase width constant.
- Sub-module tlc_rr_pick:
  - Combinational round-robin next-way selector.
  - Inputs: active_way, demand.
  - Outputs: next_way, found.
  - Instantiated only under TLC_DEMAND_SKIP_EN.

## Test plan
- Reset, then 4 ticks -> way 0 green for 4 ticks; yellow after tick 4; all-red after tick 5; way 1 green after tick 6.
- 40 consecutive ticks, defaults -> way sequence 0,1,2,3,0 with period 24 ticks, wrapping 3->0. Checker confirms at most one non-red way at all times.
- force_next at elapsed 1 of way 2 green -> YELLOW next cycle on way 2, then all-red, then way 3 green. A second force_next during yellow has no effect.
- force_next and tick in the same cycle while in GREEN -> YELLOW with elapsed = 0.
- TLC_DEMAND_SKIP_EN, active_way 0, demand = 4'b1000 -> after way 0 yellow/all-red, way 3 green. With demand = 4'b0001 at expiry -> way 0 stays GREEN, elapsed = 0, no yellow.
- ALLRED_TICKS = 0, N_WAYS = 3 -> yellow goes directly to next green; rotation 0,1,2,0.
- rst asserted mid-yellow on way 1 -> same-cycle return to way 0 green, elapsed 0.
